// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-keyboard command path.
// Holds the controller state encoding, keyboard command bytes and the ACK response.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_FINISH    = 3'd6
    } ps2_state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] byte_val);
        return ~^byte_val;
    endfunction

endpackage

// File: rtl/ps2_clk_sync.sv
// Three-flop synchroniser for one raw PS/2 line with a falling-edge strobe.
// The edge is taken between the two oldest stages so it is already metastability-filtered.
module ps2_clk_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_sync,
    output logic line_fall
);

    logic [2:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], line_in};
        end
    end

    assign line_sync = sync_reg[1];
    assign line_fall = sync_reg[2] & ~sync_reg[1];

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// Host-to-keyboard PS/2 command transmitter: inhibit, request-to-send, 11-bit frame,
// device ACK sampling and bus-idle wait, with an inter-edge watchdog.
module ps2_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output logic       done,
    output logic       ack_ok,
    output logic       err_timeout
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    // Line 0 is the PS/2 clock, line 1 the PS/2 data.
    logic [1:0] raw_line;
    logic [1:0] line_sync;
    logic [1:0] line_fall;
    logic       clk_sync;
    logic       data_sync;
    logic       clk_fall;
    logic       unused_data_fall;

    assign raw_line = {ps2_data_in, ps2_clk_in};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        ps2_clk_sync u_sync (
            .clk       (clk),
            .rst       (rst),
            .line_in   (raw_line[gi]),
            .line_sync (line_sync[gi]),
            .line_fall (line_fall[gi])
        );
    end

    assign clk_sync         = line_sync[0];
    assign data_sync        = line_sync[1];
    assign clk_fall         = line_fall[0];
    assign unused_data_fall = line_fall[1];

    ps2_state_t       state_reg,       state_next;
    logic [INH_W-1:0] inh_cnt_reg,     inh_cnt_next;
    logic [TO_W-1:0]  to_cnt_reg,      to_cnt_next;
    logic [3:0]       bit_cnt_reg,     bit_cnt_next;
    logic [7:0]       byte_reg,        byte_next;
    logic             parity_reg,      parity_next;
    logic             data_oe_reg,     data_oe_next;
    logic             ack_ok_reg,      ack_ok_next;
    logic             err_timeout_reg, err_timeout_next;
    logic             timed_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            inh_cnt_reg     <= '0;
            to_cnt_reg      <= '0;
            bit_cnt_reg     <= '0;
            byte_reg        <= '0;
            parity_reg      <= 1'b0;
            data_oe_reg     <= 1'b0;
            ack_ok_reg      <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            inh_cnt_reg     <= inh_cnt_next;
            to_cnt_reg      <= to_cnt_next;
            bit_cnt_reg     <= bit_cnt_next;
            byte_reg        <= byte_next;
            parity_reg      <= parity_next;
            data_oe_reg     <= data_oe_next;
            ack_ok_reg      <= ack_ok_next;
            err_timeout_reg <= err_timeout_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        inh_cnt_next     = inh_cnt_reg;
        bit_cnt_next     = bit_cnt_reg;
        byte_next        = byte_reg;
        parity_next      = parity_reg;
        data_oe_next     = data_oe_reg;
        ack_ok_next      = ack_ok_reg;
        err_timeout_next = err_timeout_reg;
        cmd_ready        = 1'b0;
        ps2_clk_oe       = 1'b0;
        ps2_data_oe      = 1'b0;
        done             = 1'b0;
        timed_state      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    byte_next        = cmd_data;
                    parity_next      = odd_parity(cmd_data);
                    inh_cnt_next     = '0;
                    bit_cnt_next     = '0;
                    data_oe_next     = 1'b0;
                    ack_ok_next      = 1'b0;
                    err_timeout_next = 1'b0;
                    state_next       = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                // Device clock edges here are our own pull-down echoing back; ignore them.
                ps2_clk_oe = 1'b1;
                if (inh_cnt_reg == INH_LAST) begin
                    ps2_data_oe = 1'b1;
                    state_next  = ST_RTS;
                end else begin
                    inh_cnt_next = inh_cnt_reg + 1'b1;
                end
            end
            ST_RTS: begin
                timed_state  = 1'b1;
                ps2_data_oe  = 1'b1;
                data_oe_next = 1'b1;
                state_next   = ST_SEND;
            end
            ST_SEND: begin
                timed_state = 1'b1;
                ps2_data_oe = data_oe_reg;
                if (clk_fall) begin
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg < 4'd8) begin
                        data_oe_next = ~byte_reg[bit_cnt_reg[2:0]];
                    end else if (bit_cnt_reg == 4'd8) begin
                        data_oe_next = ~parity_reg;
                    end else begin
                        data_oe_next = 1'b0;
                        state_next   = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                timed_state = 1'b1;
                if (clk_fall) begin
                    ack_ok_next = ~data_sync;
                    state_next  = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                timed_state = 1'b1;
                if (clk_sync && data_sync) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Watchdog: a silent device aborts the frame with both lines released.
        if (timed_state && !clk_fall && (to_cnt_reg == TO_LAST)) begin
            state_next       = ST_FINISH;
            data_oe_next     = 1'b0;
            ack_ok_next      = 1'b0;
            err_timeout_next = 1'b1;
        end

        if ((state_next != state_reg) || clk_fall || !timed_state) begin
            to_cnt_next = '0;
        end else begin
            to_cnt_next = to_cnt_reg + 1'b1;
        end
    end

    assign rx_inhibit  = (state_reg != ST_IDLE);
    assign ack_ok      = ack_ok_reg;
    assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Self-checking bench for ps2_cmd_ctrl with an open-drain bus and a keyboard model
// that clocks frames in and optionally ACKs; timing parameters are scaled down.
module tb_ps2_cmd_ctrl;
    import ps2_pkg::*;

    localparam int INH  = 40;
    localparam int TO   = 600;
    localparam int HALF = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       rx_inhibit, done, ack_ok, err_timeout;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_cmd_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .rx_inhibit(rx_inhibit),
        .done(done), .ack_ok(ack_ok), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Bus monitor, sampled on the falling clock edge.
    int   cyc = 0;
    int   done_cnt = 0, accept_cnt = 0, done_cyc = 0, accept_cyc = 0;
    int   clk_run = 0, both_run = 0, last_clk_run = 0, last_both = 0, rx_viol = 0;
    logic last_ack = 1'b0, last_err = 1'b0, done_oe = 1'b0, xfer = 1'b0;
    logic [7:0] accept_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            xfer     <= 1'b0;
            clk_run  <= 0;
            both_run <= 0;
        end else begin
            if (xfer && !rx_inhibit) rx_viol <= rx_viol + 1;
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
                last_ack <= ack_ok;
                last_err <= err_timeout;
                done_oe  <= ps2_clk_oe | ps2_data_oe;
                xfer     <= 1'b0;
            end
            if (cmd_valid && cmd_ready) begin
                accept_cnt  <= accept_cnt + 1;
                accept_cyc  <= cyc + 1;
                accept_data <= cmd_data;
                xfer        <= 1'b1;
            end
            if (ps2_clk_oe) begin
                clk_run <= clk_run + 1;
                if (ps2_data_oe) both_run <= both_run + 1;
            end else if (clk_run != 0) begin
                last_clk_run <= clk_run;
                last_both    <= both_run;
                clk_run      <= 0;
                both_run     <= 0;
            end
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: 8 data bits LSB first, odd parity, stop bit high.
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b};
    endfunction

    // Keyboard model: waits for request-to-send, clocks n_edges frame bits, then ACK edge.
    task automatic dev_xfer(input int n_edges, input bit ack_low,
                            output logic [9:0] bits, output bit rts_seen);
        bits = '0;
        rts_seen = 1'b0;
        for (int i = 0; i < INH + 100 && !rts_seen; i++) begin
            tick();
            if (!ps2_clk_oe && ps2_data_oe) rts_seen = 1'b1;
        end
        if (rts_seen) begin
            repeat (HALF) tick();
            for (int k = 0; k < n_edges && k < 10; k++) begin
                dev_clk = 1'b0;
                repeat (HALF) tick();
                dev_clk = 1'b1;
                bits[k] = ps2_data_in;
                repeat (HALF) tick();
            end
            if (n_edges > 10) begin
                dev_data = ack_low ? 1'b0 : 1'b1;
                repeat (4) tick();
                dev_clk = 1'b0;
                repeat (HALF) tick();
                dev_clk = 1'b1;
                repeat (2) tick();
                dev_data = 1'b1;
            end
        end
    endtask

    task automatic wait_done(input int d0, input int bound, output bit got);
        for (int i = 0; i < bound && done_cnt == d0; i++) tick();
        got = (done_cnt != d0);
    endtask

    task automatic run_xfer(input logic [7:0] cmd, input bit ack_low, input string tag);
        int d0, a0;
        bit rts, got;
        logic [9:0] bits, exp_frame;
        d0 = done_cnt;
        a0 = accept_cnt;
        exp_frame = ref_frame(cmd);
        cmd_data  = cmd;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        dev_xfer(11, ack_low, bits, rts);
        wait_done(d0, 300, got);
        tick();
        chk({tag, "_rts"}, 32'(rts), 32'd1);
        chk({tag, "_data"}, 32'(bits[7:0]), 32'(exp_frame[7:0]));
        chk({tag, "_parity"}, 32'(bits[8]), 32'(exp_frame[8]));
        chk({tag, "_stop"}, 32'(bits[9]), 32'(exp_frame[9]));
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_accept_count"}, 32'(accept_cnt - a0), 32'd1);
        chk({tag, "_ack_ok"}, 32'(last_ack), 32'(ack_low));
        chk({tag, "_err_timeout"}, 32'(last_err), 32'd0);
        chk({tag, "_inhibit_len"}, 32'(last_clk_run), 32'(INH));
        chk({tag, "_rts_overlap"}, 32'(last_both), 32'd1);
        chk({tag, "_rx_inhibit"}, 32'(rx_viol), 32'd0);
        chk({tag, "_done_oe"}, 32'(done_oe), 32'd0);
        $display("xfer %s cmd=%02h ack_low=%0d frame=%03h", tag, cmd, ack_low, bits);
    endtask

    initial begin
        int d0, a0, diff;
        bit got, rts;
        logic [9:0] bits;
        logic [7:0] rcmd, cmd_a, cmd_b;
        bit rack;

        repeat (3) tick();
        chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("rst_rx_inhibit", 32'(rx_inhibit), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ack_ok", 32'(ack_ok), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        rst = 1'b0;
        repeat (4) tick();
        chk("idle_ready", 32'(cmd_ready), 32'd1);
        $display("reset released");

        run_xfer(CMD_SET_LED, 1'b1, "set_led");
        run_xfer(CMD_ENABLE, 1'b1, "enable");
        run_xfer(8'h5A, 1'b0, "nack");
        for (int i = 0; i < 4; i++) begin
            rcmd = 8'($urandom_range(0, 255));
            rack = 1'($urandom_range(0, 1));
            run_xfer(rcmd, rack, $sformatf("rand%0d", i));
        end

        // Silent device: the watchdog must end the transfer.
        d0 = done_cnt;
        cmd_data  = CMD_ENABLE;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_done(d0, INH + TO + 100, got);
        tick();
        diff = done_cyc - accept_cyc;
        chk("to_done_seen", 32'(got), 32'd1);
        chk("to_err", 32'(last_err), 32'd1);
        chk("to_ack", 32'(last_ack), 32'd0);
        chk("to_done_oe", 32'(done_oe), 32'd0);
        checks++;
        assert (diff >= INH + 1 + TO - 2 && diff <= INH + 1 + TO + 2) else begin
            fails++;
            $error("FAIL to_latency: got %0d expected %0d", diff, INH + 1 + TO);
        end
        chk("to_ready_after", 32'(cmd_ready), 32'd1);
        $display("xfer timeout latency=%0d err=%0d", diff, last_err);

        // Reset after the fifth device edge aborts the frame silently.
        d0 = done_cnt;
        cmd_data  = 8'h3C;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        dev_xfer(5, 1'b1, bits, rts);
        chk("rst_mid_rts", 32'(rts), 32'd1);
        chk("rst_mid_busy", 32'(rx_inhibit), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_mid_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("rst_mid_rx_inhibit", 32'(rx_inhibit), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
        repeat (100) tick();
        chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rst_mid_no_resume", 32'(ps2_clk_oe | ps2_data_oe | rx_inhibit), 32'd0);
        $display("xfer reset-abort done_delta=%0d", done_cnt - d0);
        run_xfer(CMD_RESET, 1'b1, "reset_cmd");

        // cmd_valid held high: second byte is only taken on the next IDLE visit.
        cmd_a = 8'($urandom_range(0, 255));
        cmd_b = ~cmd_a;
        d0 = done_cnt;
        a0 = accept_cnt;
        cmd_data  = cmd_a;
        cmd_valid = 1'b1;
        tick();
        cmd_data = cmd_b;
        dev_xfer(11, 1'b1, bits, rts);
        wait_done(d0, 300, got);
        chk("hold_first_done", 32'(got), 32'd1);
        chk("hold_first_data", 32'(bits[7:0]), 32'(cmd_a));
        for (int i = 0; i < 10 && accept_cnt < a0 + 2; i++) tick();
        cmd_valid = 1'b0;
        chk("hold_second_accept", 32'(accept_cnt - a0), 32'd2);
        chk("hold_gap", 32'(accept_cyc - done_cyc), 32'd2);
        chk("hold_second_latch", 32'(accept_data), 32'(cmd_b));
        dev_xfer(11, 1'b1, bits, rts);
        wait_done(d0 + 1, 300, got);
        tick();
        chk("hold_second_done", 32'(got), 32'd1);
        chk("hold_second_data", 32'(bits[7:0]), 32'(cmd_b));
        chk("hold_total_accepts", 32'(accept_cnt - a0), 32'd2);
        chk("hold_total_dones", 32'(done_cnt - d0), 32'd2);
        $display("xfer hold first=%02h second=%02h", cmd_a, cmd_b);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/ps2_cmd_ctrl.md
PS2_CMD_CTRL -- requirements
Module: ps2_cmd_ctrl

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clk cycles ps2_clk is held low before request-to-send (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, max clk cycles between device clock edges before abort (15 ms at 50 MHz).
REQ-003 SHALL have port clk  in  1  system clock.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  in  1  command byte offered.
REQ-006 SHALL have port cmd_data  in  8  host-to-keyboard command byte.
REQ-007 SHALL have port cmd_ready  out  1  controller can accept a command.
REQ-008 SHALL have port ps2_clk_in  in  1  raw (asynchronous) PS/2 clock line.
REQ-009 SHALL have port ps2_data_in  in  1  raw (asynchronous) PS/2 data line.
REQ-010 SHALL have port ps2_clk_oe  out  1  1 = pull PS/2 clock low, 0 = release.
REQ-011 SHALL have port ps2_data_oe  out  1  1 = pull PS/2 data low, 0 = release.
REQ-012 SHALL have port rx_inhibit  out  1  1 = keyboard receive path must ignore the bus.
REQ-013 SHALL have port done  out  1  one-cycle pulse at end of a transfer, success or failure.
REQ-014 SHALL have port ack_ok  out  1  valid with done: device drove the ACK bit low.
REQ-015 SHALL have port err_timeout  out  1  valid with done: transfer aborted by timeout.

Function
REQ-016 SHALL synchronise ps2_clk_in and ps2_data_in through 3 flops and flag a falling edge when sync stage 2 = 1 and stage 1 = 0.
REQ-017 SHALL use states IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE and FINISH.
REQ-018 In IDLE: cmd_ready = 1 and all oe = 0; on cmd_valid && cmd_ready, latch cmd_data, compute odd parity, and go to INHIBIT.
REQ-019 In INHIBIT: ps2_clk_oe = 1 for exactly INHIBIT_CYCLES cycles, with ps2_data_oe asserted on the last cycle; then go to RTS.
REQ-020 In RTS: ps2_clk_oe = 0 and ps2_data_oe = 1 (start bit); go to SEND.
REQ-021 In SEND, on device falling edges 1-8: drive data bit (edge-1), LSB first; ps2_data_oe = ~bit.
REQ-022 In SEND, on edge 9: drive parity; on edge 10: release data (stop bit); then go to ACK.
REQ-023 In ACK, on the next falling edge: ack_ok_reg = ~sync_data; go to WAIT_IDLE.
REQ-024 WAIT_IDLE SHALL wait until synchronised clock and data are both 1, then go to FINISH.
REQ-025 FINISH SHALL pulse done for 1 cycle with ack_ok and err_timeout valid, then return to IDLE; cmd_ready = 0 in FINISH.
REQ-026 Timeout counter SHALL clear on every state change and on every falling edge; in RTS/SEND/ACK/WAIT_IDLE, reaching TIMEOUT_CYCLES SHALL release both lines, set err_timeout = 1 and ack_ok = 0, and go to FINISH.
REQ-027 rx_inhibit SHALL be 1 in every state except IDLE.
REQ-028 The bit counter SHALL be 4 bits wide, count 0-10, and clear on entry to INHIBIT; extra falling edges in WAIT_IDLE SHALL be ignored.
REQ-029 cmd_valid outside IDLE SHALL be ignored and SHALL NOT corrupt the latched byte.
REQ-030 A falling edge seen in INHIBIT (device contending) SHALL be ignored.

Reset
REQ-031 rst SHALL immediately force state IDLE and set ps2_clk_oe = ps2_data_oe = 0, rx_inhibit = 0, done = ack_ok = err_timeout = 0, and all counters and sync flops to 0 (sync flops at 1 would also be legal; 0 is chosen).
REQ-032 rst asserted mid-transfer SHALL abort the transfer with no done pulse; the transfer SHALL NOT resume after reset release.

Structure
REQ-033 Package ps2_pkg SHALL hold the state enum, command constants (SET_LED 8'hED, ENABLE 8'hF4, RESET 8'hFF), and the response constant ACK 8'hFA.
REQ-034 Sub-module ps2_clk_sync (3-flop synchroniser plus falling-edge pulse) SHALL be instantiated once per line.

Verification
REQ-035 cmd 8'hED, device model clocks at 12.5 kHz and ACKs low -> serial bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done with ack_ok = 1 and err_timeout = 0.
REQ-036 cmd 8'hF4 -> parity 0; ps2_clk_oe high for exactly 5000 cycles; rx_inhibit high from accept until done.
REQ-037 Device leaves data high at the ACK edge -> done with ack_ok = 0 and err_timeout = 0.
REQ-038 Device never clocks -> done exactly INHIBIT_CYCLES + 1 + TIMEOUT_CYCLES cycles after accept (±2 sync), err_timeout = 1, both oe = 0.
REQ-039 rst pulsed after edge 5 -> oe = 0 within the same cycle, no done, cmd_ready = 1 after release; a following cmd 8'hFF completes with ack_ok = 1.
REQ-040 cmd_valid held high continuously through a transfer -> exactly one transfer per IDLE visit, back-to-back, with the second byte sampled only in IDLE.
